aes_round_sequencer: RTL and testbench

Parametrised round controller for the AES encoder datapath, supporting AES-128/192/256 (Nr = 10/12/14) selected per block. It accepts a start request, sequences round 0 (initial AddRoundKey) through round Nr, and drives the per-stage enables to the SubBytes, ShiftRows, MixColumns, AddRoundKey and key-schedule units. It adds datapath stall, abort, a done/acknowledge handshake, configuration-error detection and a completed-block counter. It sits between the block-level host interface and the round datapath.

---
 rtl/aes_round_sequencer.sv | 150 +++++++++++++++
 tb/tb_aes_round_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_sequencer
// Brief    : AES-128/192/256 round controller driving per-stage datapath enables
// Revision : 1.0  initial release
// ============================================================================
module aes_round_sequencer #(
    parameter int MAX_NR = 14,
    parameter int RND_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [1:0]        key_mode,
    input  logic              stall,
    input  logic              abort,
    input  logic              done_ack,
    output logic              accept,
    output logic              busy,
    output logic [RND_W-1:0]  rnd_no,
    output logic [RND_W-1:0]  nr_cur,
    output logic              enbSB,
    output logic              enbSR,
    output logic              enbMC,
    output logic              enbAR,
    output logic              enbKS,
    output logic              last_rnd,
    output logic              done,
    output logic              cfg_err,
    output logic [MAX_NR:0]   completed_round,
    output logic [CNT_W-1:0]  blk_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [RND_W-1:0]   r_rnd, w_rnd_nxt;
    logic [RND_W-1:0]   r_nr, w_nr_nxt;
    logic               r_cfg_err, w_cfg_err_nxt;
    logic [CNT_W-1:0]   r_blk_cnt, w_blk_cnt_nxt;
    logic [4:0]         w_nr_dec;
    logic               w_mode_ok;
    logic               w_run_go;

    // Reserved mode and any Nr beyond what this instance supports are rejected
    always_comb begin
        w_nr_dec = 5'd0;
        case (key_mode)
            2'b00:   w_nr_dec = 5'd10;
            2'b01:   w_nr_dec = 5'd12;
            2'b10:   w_nr_dec = 5'd14;
            default: w_nr_dec = 5'd0;
        endcase
        w_mode_ok = (key_mode != 2'b11) && (int'(w_nr_dec) <= MAX_NR);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_rnd     <= '0;
            r_nr      <= '0;
            r_cfg_err <= 1'b0;
            r_blk_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rnd     <= w_rnd_nxt;
            r_nr      <= w_nr_nxt;
            r_cfg_err <= w_cfg_err_nxt;
            r_blk_cnt <= w_blk_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rnd_nxt     = r_rnd;
        w_nr_nxt      = r_nr;
        w_cfg_err_nxt = 1'b0;
        w_blk_cnt_nxt = r_blk_cnt;
        accept        = 1'b0;
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_rnd_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_mode_ok) begin
                            accept      = 1'b1;
                            w_nr_nxt    = RND_W'(w_nr_dec);
                            w_rnd_nxt   = '0;
                            w_state_nxt = ST_RUN;
                        end else begin
                            w_cfg_err_nxt = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (r_rnd < r_nr) begin
                            w_rnd_nxt = r_rnd + RND_W'(1);
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (done_ack) begin
                        w_state_nxt   = ST_IDLE;
                        w_rnd_nxt     = '0;
                        w_blk_cnt_nxt = r_blk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_rnd_nxt   = '0;
                end
            endcase
        end
    end

    // Round 0 is the bare AddRoundKey; MixColumns is skipped in the final round
    assign w_run_go = (r_state == ST_RUN) && !stall;
    assign enbAR    = w_run_go;
    assign enbKS    = w_run_go;
    assign enbSB    = w_run_go && (r_rnd != '0);
    assign enbSR    = w_run_go && (r_rnd != '0);
    assign enbMC    = w_run_go && (r_rnd != '0) && (r_rnd != r_nr);

    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign last_rnd = (r_state == ST_RUN) && (r_rnd == r_nr);
    assign rnd_no   = r_rnd;
    assign nr_cur   = r_nr;
    assign cfg_err  = r_cfg_err;
    assign blk_cnt  = r_blk_cnt;

    always_comb begin
        completed_round = '0;
        for (int i = 0; i <= MAX_NR; i++) begin
            completed_round[i] = (r_state == ST_RUN) && (r_rnd == RND_W'(i));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// Testbench for aes_round_sequencer: table-driven AES-128 run plus directed
// corner sequences on a default instance and a MAX_NR=12 / CNT_W=2 instance.
module tb_aes_round_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start, stall, abort, done_ack;
    logic [1:0]  key_mode;
    logic        accept, busy, last_rnd, done, cfg_err;
    logic        enbSB, enbSR, enbMC, enbAR, enbKS;
    logic [3:0]  rnd_no, nr_cur;
    logic [14:0] completed_round;
    logic [15:0] blk_cnt;

    logic        b_start, b_stall, b_abort, b_done_ack;
    logic [1:0]  b_key_mode;
    logic        b_accept, b_busy, b_last_rnd, b_done, b_cfg_err;
    logic        b_enbSB, b_enbSR, b_enbMC, b_enbAR, b_enbKS;
    logic [3:0]  b_rnd_no, b_nr_cur;
    logic [12:0] b_completed_round;
    logic [1:0]  b_blk_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_round_sequencer u_dut (
        .clk(clk), .rstn(rstn), .start(start), .key_mode(key_mode),
        .stall(stall), .abort(abort), .done_ack(done_ack),
        .accept(accept), .busy(busy), .rnd_no(rnd_no), .nr_cur(nr_cur),
        .enbSB(enbSB), .enbSR(enbSR), .enbMC(enbMC), .enbAR(enbAR), .enbKS(enbKS),
        .last_rnd(last_rnd), .done(done), .cfg_err(cfg_err),
        .completed_round(completed_round), .blk_cnt(blk_cnt)
    );

    aes_round_sequencer #(.MAX_NR(12), .RND_W(4), .CNT_W(2)) u_small (
        .clk(clk), .rstn(rstn), .start(b_start), .key_mode(b_key_mode),
        .stall(b_stall), .abort(b_abort), .done_ack(b_done_ack),
        .accept(b_accept), .busy(b_busy), .rnd_no(b_rnd_no), .nr_cur(b_nr_cur),
        .enbSB(b_enbSB), .enbSR(b_enbSR), .enbMC(b_enbMC), .enbAR(b_enbAR), .enbKS(b_enbKS),
        .last_rnd(b_last_rnd), .done(b_done), .cfg_err(b_cfg_err),
        .completed_round(b_completed_round), .blk_cnt(b_blk_cnt)
    );

    typedef struct {
        logic        st;
        logic [1:0]  md;
        logic        sl, ab, ak;
        logic        e_acc, e_busy;
        logic [3:0]  e_rnd;
        logic [4:0]  e_en;
        logic        e_last, e_done, e_cfg;
        logic [15:0] e_blk;
        logic [3:0]  e_nr;
    } vec_t;

    vec_t tv[0:20];

    function automatic vec_t mk(input logic st, input logic [1:0] md, input logic sl,
                                input logic ab, input logic ak, input logic ea,
                                input logic eb, input logic [3:0] er, input logic [4:0] ee,
                                input logic el, input logic ed, input logic ec,
                                input logic [15:0] ebk, input logic [3:0] enr);
        vec_t v;
        v.st = st; v.md = md; v.sl = sl; v.ab = ab; v.ak = ak;
        v.e_acc = ea; v.e_busy = eb; v.e_rnd = er; v.e_en = ee;
        v.e_last = el; v.e_done = ed; v.e_cfg = ec; v.e_blk = ebk; v.e_nr = enr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] ens();
        return {enbSB, enbSR, enbMC, enbAR, enbKS};
    endfunction

    task automatic wait_small_done();
        int n = 0;
        while (!b_done && n < 40) begin
            tick();
            n++;
        end
        chk("small_done_bound", 64'(b_done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [14:0] exp_onehot;
        logic [14:0] one15;

        one15 = 15'd1;
        rstn = 1'b0; start = 0; key_mode = 0; stall = 0; abort = 0; done_ack = 0;
        b_start = 0; b_key_mode = 0; b_stall = 0; b_abort = 0; b_done_ack = 0;

        tv[0] = mk(1, 2'd0, 0, 0, 0, 1, 0, 4'd0, 5'b00000, 0, 0, 0, 16'd0, 4'd0);
        for (int r = 0; r <= 10; r++) begin
            tv[1 + r] = mk(0, 2'd0, 0, 0, 0, 0, 1, 4'(r),
                           {r > 0, r > 0, (r > 0) && (r < 10), 1'b1, 1'b1},
                           r == 10, 0, 0, 16'd0, 4'd10);
        end
        tv[12] = mk(0, 2'd0, 0, 0, 1, 0, 1, 4'd10, 5'b00000, 0, 1, 0, 16'd0, 4'd10);
        tv[13] = mk(0, 2'd0, 0, 0, 0, 0, 0, 4'd0,  5'b00000, 0, 0, 0, 16'd1, 4'd10);
        tv[14] = mk(1, 2'd3, 0, 0, 0, 0, 0, 4'd0,  5'b00000, 0, 0, 0, 16'd1, 4'd10);
        tv[15] = mk(0, 2'd0, 0, 0, 0, 0, 0, 4'd0,  5'b00000, 0, 0, 1, 16'd1, 4'd10);
        tv[16] = mk(0, 2'd0, 0, 0, 0, 0, 0, 4'd0,  5'b00000, 0, 0, 0, 16'd1, 4'd10);
        tv[17] = mk(1, 2'd0, 0, 1, 0, 0, 0, 4'd0,  5'b00000, 0, 0, 0, 16'd1, 4'd10);
        tv[18] = mk(0, 2'd0, 0, 0, 0, 0, 0, 4'd0,  5'b00000, 0, 0, 0, 16'd1, 4'd10);
        tv[19] = mk(0, 2'd0, 0, 0, 1, 0, 0, 4'd0,  5'b00000, 0, 0, 0, 16'd1, 4'd10);
        tv[20] = mk(0, 2'd0, 0, 0, 0, 0, 0, 4'd0,  5'b00000, 0, 0, 0, 16'd1, 4'd10);

        // Reset state
        tick(); tick();
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_rnd",   64'(rnd_no), 64'd0);
        chk("rst_outs",  64'({done, cfg_err, ens(), completed_round, nr_cur, blk_cnt}), 64'd0);
        rstn = 1'b1;
        tick();

        // AES-128 run, invalid mode, abort+start, stray done_ack
        for (int i = 0; i <= 20; i++) begin
            start = tv[i].st; key_mode = tv[i].md; stall = tv[i].sl;
            abort = tv[i].ab; done_ack = tv[i].ak;
            #1;
            exp_onehot = (tv[i].e_busy && !tv[i].e_done) ? (one15 << tv[i].e_rnd) : 15'd0;
            chk($sformatf("vec%0d", i),
                64'({accept, busy, rnd_no, ens(), last_rnd, done, cfg_err, blk_cnt, nr_cur, completed_round}),
                64'({tv[i].e_acc, tv[i].e_busy, tv[i].e_rnd, tv[i].e_en, tv[i].e_last,
                     tv[i].e_done, tv[i].e_cfg, tv[i].e_blk, tv[i].e_nr, exp_onehot}));
            tick();
        end
        start = 0; key_mode = 0; abort = 0; done_ack = 0;

        // AES-256 with a 3-cycle stall at round 5
        start = 1; key_mode = 2'd2; #1;
        chk("a256_accept", 64'(accept), 64'd1);
        tick(); start = 0;
        repeat (5) tick();
        chk("a256_rnd5", 64'(rnd_no), 64'd5);
        stall = 1;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall_hold", 64'({rnd_no, ens()}), 64'({4'd5, 5'b00000}));
            tick();
        end
        stall = 0; #1;
        chk("stall_release", 64'({rnd_no, ens()}), 64'({4'd5, 5'b11111}));
        repeat (9) tick();
        chk("a256_last", 64'({rnd_no, last_rnd, ens(), done}), 64'({4'd14, 1'b1, 5'b11011, 1'b0}));
        tick();
        chk("a256_done", 64'({done, rnd_no, nr_cur, busy}), 64'({1'b1, 4'd14, 4'd14, 1'b1}));
        done_ack = 1; tick(); done_ack = 0;
        chk("a256_blk", 64'({busy, blk_cnt}), 64'({1'b0, 16'd2}));

        // AES-192 aborted at round 7, then restarted
        start = 1; key_mode = 2'd1; tick(); start = 0;
        repeat (7) tick();
        chk("a192_rnd7", 64'(rnd_no), 64'd7);
        abort = 1; tick(); abort = 0;
        chk("abort_idle", 64'({busy, rnd_no, done, blk_cnt}), 64'({1'b0, 4'd0, 1'b0, 16'd2}));
        start = 1; key_mode = 2'd1; #1;
        chk("abort_restart", 64'(accept), 64'd1);
        tick(); start = 0;
        chk("a192_nr", 64'({busy, nr_cur}), 64'({1'b1, 4'd12}));

        // Done held for 5 cycles with start high
        repeat (13) tick();
        chk("a192_done", 64'(done), 64'd1);
        start = 1;
        for (int h = 0; h < 5; h++) begin
            #1;
            chk("done_hold", 64'({done, accept}), 64'({1'b1, 1'b0}));
            tick();
        end
        done_ack = 1; #1;
        chk("done_ack_noacc", 64'(accept), 64'd0);
        tick(); done_ack = 0;
        chk("after_ack", 64'({busy, accept, blk_cnt}), 64'({1'b0, 1'b1, 16'd3}));
        tick(); start = 0;

        // Reset mid-run at round 4
        repeat (4) tick();
        chk("pre_reset_rnd", 64'(rnd_no), 64'd4);
        rstn = 0; tick();
        chk("midrst_outs",
            64'({busy, rnd_no, nr_cur, done, cfg_err, ens(), last_rnd, completed_round, blk_cnt}), 64'd0);
        rstn = 1; tick();

        // MAX_NR=12 instance rejects AES-256
        b_start = 1; b_key_mode = 2'd2; #1;
        chk("small_rej_acc", 64'(b_accept), 64'd0);
        tick(); b_start = 0;
        chk("small_cfg_err", 64'({b_cfg_err, b_busy}), 64'({1'b1, 1'b0}));
        tick();
        chk("small_cfg_clr", 64'({b_cfg_err, b_busy}), 64'd0);

        // CNT_W=2 counter wrap after five acknowledged AES-192 blocks
        for (int b = 0; b < 5; b++) begin
            b_start = 1; b_key_mode = 2'd1; #1;
            chk("small_acc", 64'(b_accept), 64'd1);
            tick(); b_start = 0;
            chk("small_nr", 64'(b_nr_cur), 64'd12);
            wait_small_done();
            b_done_ack = 1; tick(); b_done_ack = 0;
        end
        chk("small_wrap", 64'({b_busy, b_blk_cnt}), 64'({1'b0, 2'd1}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
